// File: rtl/scr1_vec_mem_seq.sv
// Vector memory sequencer: moves one MPRF vector register to or from LANE
// consecutive memory words, issuing one data-memory transaction per lane.
module scr1_vec_mem_seq #(
    parameter int LANE = 4,
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_is_store,
    input  logic [31:0]          cmd_addr,
    input  logic [AW-1:0]        cmd_vreg,
    output logic                 done,
    output logic                 done_err,
    output logic [AW-1:0]        seq2mprf_rs_addr,
    output logic                 seq2mprf_rs_is_vector,
    input  logic [LANE*XLEN-1:0] mprf2seq_rs_data,
    output logic                 seq2mprf_w_req,
    output logic [AW-1:0]        seq2mprf_rd_addr,
    output logic                 seq2mprf_rd_is_vector,
    output logic [LANE*XLEN-1:0] seq2mprf_rd_data,
    output logic                 dmem_req,
    output logic                 dmem_cmd,
    output logic [31:0]          dmem_addr,
    output logic [XLEN-1:0]      dmem_wdata,
    input  logic                 dmem_req_ack,
    input  logic [XLEN-1:0]      dmem_rdata,
    input  logic [1:0]           dmem_resp
);

    localparam int            LW        = $clog2(LANE);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANE - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_VREG,
        REQ,
        WAIT_RESP,
        WR_VREG,
        DONE
    } state_e;

    state_e               state_q;
    state_e               state_d;
    logic [LW-1:0]        lane_q;
    logic                 is_store_q;
    logic [31:0]          addr_q;
    logic [AW-1:0]        vreg_q;
    logic                 err_q;
    logic [LANE*XLEN-1:0] buf_q;

    logic                 misalign;
    logic                 resp_take;
    logic                 resp_ok;
    logic                 resp_err;
    logic                 last_lane;
    logic [XLEN-1:0]      lane_word;

    assign misalign  = (cmd_addr[1:0] != 2'b00);
    // A response is consumed in WAIT_RESP, or in REQ when it arrives with the ack.
    assign resp_take = (state_q == WAIT_RESP) || ((state_q == REQ) && dmem_req_ack);
    assign resp_ok   = resp_take && (dmem_resp == 2'b01);
    assign resp_err  = resp_take && (dmem_resp == 2'b10);
    assign last_lane = (lane_q == LAST_LANE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (misalign) begin
                        state_d = DONE;
                    end else if (cmd_is_store) begin
                        state_d = RD_VREG;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            RD_VREG: state_d = REQ;
            REQ, WAIT_RESP: begin
                if (resp_err) begin
                    state_d = DONE;
                end else if (resp_ok) begin
                    if (!last_lane) begin
                        state_d = REQ;
                    end else if (is_store_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = WR_VREG;
                    end
                end else if ((state_q == REQ) && dmem_req_ack) begin
                    state_d = WAIT_RESP;
                end
            end
            WR_VREG: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the vector buffer is reset like any other register; it is only
    // LANE words of flops, not an array macro, so the reset costs nothing odd.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q     <= '0;
            is_store_q <= 1'b0;
            addr_q     <= '0;
            vreg_q     <= '0;
            err_q      <= 1'b0;
            buf_q      <= '0;
        end else begin
            if ((state_q == IDLE) && cmd_valid) begin
                is_store_q <= cmd_is_store;
                addr_q     <= cmd_addr;
                vreg_q     <= cmd_vreg;
                lane_q     <= '0;
                err_q      <= misalign;
            end
            if (state_q == RD_VREG) begin
                buf_q <= mprf2seq_rs_data;
            end
            if (resp_ok) begin
                if (!is_store_q) begin
                    for (int i = 0; i < LANE; i++) begin
                        if (lane_q == LW'(i)) begin
                            buf_q[i*XLEN +: XLEN] <= dmem_rdata;
                        end
                    end
                end
                if (!last_lane) begin
                    lane_q <= lane_q + LW'(1);
                end
            end
            if (resp_err) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        lane_word = '0;
        for (int i = 0; i < LANE; i++) begin
            if (lane_q == LW'(i)) begin
                lane_word = buf_q[i*XLEN +: XLEN];
            end
        end
    end

    assign cmd_ready             = (state_q == IDLE);
    assign done                  = (state_q == DONE);
    assign done_err              = done && err_q;

    assign seq2mprf_rs_is_vector = 1'b1;
    assign seq2mprf_rs_addr      = (state_q == RD_VREG) ? vreg_q : '0;

    assign seq2mprf_rd_is_vector = 1'b1;
    assign seq2mprf_w_req        = (state_q == WR_VREG);
    assign seq2mprf_rd_addr      = seq2mprf_w_req ? vreg_q : '0;
    assign seq2mprf_rd_data      = buf_q;

    // Address arithmetic wraps modulo 2^32 by construction of the 32-bit add.
    assign dmem_req              = (state_q == REQ);
    assign dmem_cmd              = dmem_req && is_store_q;
    assign dmem_addr             = dmem_req ? (addr_q + 32'({lane_q, 2'b00})) : '0;
    assign dmem_wdata            = dmem_req ? lane_word : '0;

endmodule

// File: tb/tb_scr1_vec_mem_seq.sv
// Self-checking bench for scr1_vec_mem_seq: memory/MPRF models plus a
// command-level reference predicting transactions, results and latency.
module tb_scr1_vec_mem_seq;

    localparam int LANE = 4;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int VW   = LANE * XLEN;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_is_store = 1'b0;
    logic [31:0]     cmd_addr = '0;
    logic [AW-1:0]   cmd_vreg = '0;
    logic            done;
    logic            done_err;
    logic [AW-1:0]   seq2mprf_rs_addr;
    logic            seq2mprf_rs_is_vector;
    logic [VW-1:0]   mprf2seq_rs_data;
    logic            seq2mprf_w_req;
    logic [AW-1:0]   seq2mprf_rd_addr;
    logic            seq2mprf_rd_is_vector;
    logic [VW-1:0]   seq2mprf_rd_data;
    logic            dmem_req;
    logic            dmem_cmd;
    logic [31:0]     dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_req_ack = 1'b0;
    logic [XLEN-1:0] dmem_rdata = '0;
    logic [1:0]      dmem_resp = 2'b00;

    always #5 clk = ~clk;

    scr1_vec_mem_seq #(.LANE(LANE), .XLEN(XLEN), .AW(AW)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_is_store          (cmd_is_store),
        .cmd_addr              (cmd_addr),
        .cmd_vreg              (cmd_vreg),
        .done                  (done),
        .done_err              (done_err),
        .seq2mprf_rs_addr      (seq2mprf_rs_addr),
        .seq2mprf_rs_is_vector (seq2mprf_rs_is_vector),
        .mprf2seq_rs_data      (mprf2seq_rs_data),
        .seq2mprf_w_req        (seq2mprf_w_req),
        .seq2mprf_rd_addr      (seq2mprf_rd_addr),
        .seq2mprf_rd_is_vector (seq2mprf_rd_is_vector),
        .seq2mprf_rd_data      (seq2mprf_rd_data),
        .dmem_req              (dmem_req),
        .dmem_cmd              (dmem_cmd),
        .dmem_addr             (dmem_addr),
        .dmem_wdata            (dmem_wdata),
        .dmem_req_ack          (dmem_req_ack),
        .dmem_rdata            (dmem_rdata),
        .dmem_resp             (dmem_resp)
    );

    int checks = 0;
    int errors = 0;

    // Memory and MPRF models, owned by the responder process below.
    logic [VW-1:0]   vregs [32];
    logic [XLEN-1:0] mem [logic [31:0]];
    bit              init_done = 1'b0;

    assign mprf2seq_rs_data = (seq2mprf_rs_addr == '0) ? '0 : vregs[seq2mprf_rs_addr];

    function automatic logic [XLEN-1:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'hC0DE_0000);
    endfunction

    function automatic logic [VW-1:0] vreg_rd(input logic [AW-1:0] v);
        return (v == '0) ? '0 : vregs[v];
    endfunction

    // Responder knobs, written by the stimulus process only.
    int            ack_delay = 0;
    int            resp_delay = 0;
    bit            same_cycle = 1'b0;
    int            err_txn = -1;
    int            pre_kind = 0;
    logic [31:0]   pre_addr = '0;
    logic [VW-1:0] pre_data = '0;

    // Responder state and observation log.
    bit              pend = 1'b0;
    bit              hold = 1'b0;
    int              ack_cnt = 0;
    int              resp_cnt = 0;
    logic [31:0]     h_addr;
    logic            h_cmd;
    logic [XLEN-1:0] h_wdata;
    logic [31:0]     cur_addr;
    logic            cur_cmd;
    logic [XLEN-1:0] cur_wdata;
    int              unstable_cnt = 0;
    int              overlap_cnt = 0;
    int              done_cnt = 0;
    int              wreq_cnt = 0;
    logic [AW-1:0]   wreq_addr;
    logic [VW-1:0]   wreq_data;
    logic [31:0]     txn_addr [$];
    logic            txn_cmd [$];
    logic [XLEN-1:0] txn_wdata [$];

    task automatic give_resp();
        int idx;
        idx = txn_addr.size() - 1;
        if (idx == err_txn) begin
            dmem_resp = 2'b10;
        end else begin
            dmem_resp = 2'b01;
            if (cur_cmd) mem[cur_addr] = cur_wdata;
            else         dmem_rdata = mem_rd(cur_addr);
        end
    endtask

    always @(negedge clk) begin
        dmem_req_ack = 1'b0;
        dmem_resp    = 2'b00;
        dmem_rdata   = $urandom;
        if (!init_done) begin
            for (int i = 0; i < 32; i++) vregs[i] = '0;
            init_done = 1'b1;
        end
        if (pre_kind == 1) mem[pre_addr] = pre_data[XLEN-1:0];
        if (pre_kind == 2) vregs[pre_addr[AW-1:0]] = pre_data;
        if (!rst_n) begin
            pend = 1'b0; hold = 1'b0; ack_cnt = 0; resp_cnt = 0;
        end else begin
            if (dmem_req) begin
                if (hold && (dmem_addr !== h_addr || dmem_cmd !== h_cmd || dmem_wdata !== h_wdata))
                    unstable_cnt++;
                h_addr = dmem_addr; h_cmd = dmem_cmd; h_wdata = dmem_wdata; hold = 1'b1;
            end else begin
                hold = 1'b0;
            end
            if (seq2mprf_w_req && dmem_req) overlap_cnt++;
            if (done) done_cnt++;
            if (seq2mprf_w_req) begin
                wreq_cnt++;
                wreq_addr = seq2mprf_rd_addr;
                wreq_data = seq2mprf_rd_data;
                if (seq2mprf_rd_addr != '0) vregs[seq2mprf_rd_addr] = seq2mprf_rd_data;
            end
            if (pend) begin
                if (resp_cnt < resp_delay) resp_cnt++;
                else begin give_resp(); pend = 1'b0; end
            end else if (dmem_req) begin
                if (ack_cnt < ack_delay) begin
                    ack_cnt++;
                end else begin
                    dmem_req_ack = 1'b1;
                    ack_cnt = 0;
                    hold = 1'b0;
                    cur_addr = dmem_addr; cur_cmd = dmem_cmd; cur_wdata = dmem_wdata;
                    txn_addr.push_back(dmem_addr);
                    txn_cmd.push_back(dmem_cmd);
                    txn_wdata.push_back(dmem_wdata);
                    if (same_cycle) give_resp();
                    else begin pend = 1'b1; resp_cnt = 0; end
                end
            end
        end
    end

    task automatic preload(input int kind, input logic [31:0] a, input logic [VW-1:0] d);
        @(posedge clk);
        pre_kind = kind; pre_addr = a; pre_data = d;
        @(negedge clk);
        #1 pre_kind = 0;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < LANE; i++) v[i*XLEN +: XLEN] = $urandom;
        return v;
    endfunction

    // Command-level reference: one call issues a command and checks everything it implies.
    task automatic run_cmd(input string name, input bit st, input logic [31:0] addr,
                           input logic [AW-1:0] vr, input int err_at, input int ackd,
                           input int respd, input bit same);
        logic [VW-1:0]   old_v, exp_v, ld_v;
        logic [XLEN-1:0] exp_w [LANE];
        bit              mis, exp_err, seen;
        int              n_issue, per, exp_lat, t0, w0, d0, u0, o0, cyc, got_n, exp_w_n;

        mis     = (addr[1:0] != 2'b00);
        exp_err = mis || (err_at >= 0);
        n_issue = mis ? 0 : ((err_at >= 0) ? err_at + 1 : LANE);
        old_v   = vreg_rd(vr);
        for (int i = 0; i < LANE; i++) begin
            exp_w[i] = st ? old_v[i*XLEN +: XLEN] : mem_rd(addr + 32'(4 * i));
            ld_v[i*XLEN +: XLEN] = exp_w[i];
        end
        exp_v   = (!st && !exp_err && vr != '0) ? ld_v : old_v;
        exp_w_n = (!st && !exp_err) ? 1 : 0;
        per     = ackd + 1 + (same ? 0 : respd + 1);
        exp_lat = mis ? 2 : 1 + (st ? 1 : 0) + n_issue * per + exp_w_n + 1;

        t0 = txn_addr.size(); w0 = wreq_cnt; d0 = done_cnt; u0 = unstable_cnt; o0 = overlap_cnt;
        ack_delay = ackd; resp_delay = respd; same_cycle = same;
        err_txn = (err_at >= 0) ? t0 + err_at : -1;

        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL %s cmd_ready: got %b want 1", name, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_is_store = st; cmd_addr = addr; cmd_vreg = vr;
        @(posedge clk);
        cyc = 1; seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            cyc++;
            if (k == 0) begin
                cmd_valid = 1'b0; cmd_is_store = ~st; cmd_addr = $urandom; cmd_vreg = AW'($urandom);
            end
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL %s done: timeout after %0d cycles", name, cyc);
            return;
        end
        checks++;
        if (cyc != exp_lat) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
        end
        checks++;
        if (done_err !== exp_err) begin
            errors++; $display("FAIL %s done_err: got %b want %b", name, done_err, exp_err);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL %s done_pulse: done=%b ready=%b want 0/1", name, done, cmd_ready);
        end
        got_n = txn_addr.size() - t0;
        checks++;
        if (got_n != n_issue) begin
            errors++; $display("FAIL %s txn_count: got %0d want %0d", name, got_n, n_issue);
        end
        for (int i = 0; i < n_issue && i < got_n; i++) begin
            checks++;
            if (txn_addr[t0+i] !== addr + 32'(4 * i) || txn_cmd[t0+i] !== st ||
                (st && txn_wdata[t0+i] !== exp_w[i])) begin
                errors++;
                $display("FAIL %s lane%0d: got addr=%h cmd=%b wdata=%h want addr=%h cmd=%b wdata=%h",
                         name, i, txn_addr[t0+i], txn_cmd[t0+i], txn_wdata[t0+i],
                         addr + 32'(4 * i), st, exp_w[i]);
            end
        end
        checks++;
        if (wreq_cnt - w0 != exp_w_n) begin
            errors++; $display("FAIL %s w_req_count: got %0d want %0d", name, wreq_cnt - w0, exp_w_n);
        end
        if (exp_w_n == 1) begin
            checks++;
            if (wreq_addr !== vr || wreq_data !== ld_v) begin
                errors++;
                $display("FAIL %s w_req_data: got %0d/%h want %0d/%h", name, wreq_addr, wreq_data, vr, ld_v);
            end
        end
        checks++;
        if (vreg_rd(vr) !== exp_v) begin
            errors++; $display("FAIL %s vreg: got %h want %h", name, vreg_rd(vr), exp_v);
        end
        checks++;
        if (done_cnt - d0 != 1 || unstable_cnt != u0 || overlap_cnt != o0) begin
            errors++;
            $display("FAIL %s protocol: done_pulses=%0d unstable=%0d overlap=%0d want 1/0/0",
                     name, done_cnt - d0, unstable_cnt - u0, overlap_cnt - o0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({cmd_ready, done, done_err, seq2mprf_rs_is_vector, seq2mprf_rd_is_vector,
             seq2mprf_w_req, dmem_req, dmem_cmd} !== 8'b1001_1000) begin
            errors++;
            $display("FAIL reset_ctrl: got ready=%b done=%b err=%b rsv=%b rdv=%b wreq=%b req=%b cmd=%b",
                     cmd_ready, done, done_err, seq2mprf_rs_is_vector, seq2mprf_rd_is_vector,
                     seq2mprf_w_req, dmem_req, dmem_cmd);
        end
        checks++;
        if (dmem_addr !== '0 || dmem_wdata !== '0 || seq2mprf_rd_data !== '0 ||
            seq2mprf_rs_addr !== '0 || seq2mprf_rd_addr !== '0) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h wdata=%h rd_data=%h rs=%0d rd=%0d want all 0",
                     dmem_addr, dmem_wdata, seq2mprf_rd_data, seq2mprf_rs_addr, seq2mprf_rd_addr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_basic();
        for (int i = 0; i < LANE; i++) preload(1, 32'h100 + 32'(4 * i), VW'(32'h11 * (i + 1)));
        preload(2, 32'd5, rand_vec());
        run_cmd("load_basic", 1'b0, 32'h100, 5'd5, -1, 0, 0, 1'b0);
    endtask

    task automatic test_store_delayed();
        preload(2, 32'd7, {32'hD, 32'hC, 32'hB, 32'hA});
        run_cmd("store_ackdly", 1'b1, 32'h200, 5'd7, -1, 3, 0, 1'b0);
    endtask

    task automatic test_misalign();
        run_cmd("misalign", 1'b0, 32'h102, 5'd4, -1, 0, 0, 1'b0);
    endtask

    task automatic test_resp_error();
        preload(2, 32'd9, rand_vec());
        run_cmd("resp_err", 1'b0, 32'h300, 5'd9, 2, 0, 1, 1'b0);
    endtask

    task automatic test_store_wrap();
        run_cmd("store_wrap_v0", 1'b1, 32'hFFFF_FFF8, 5'd0, -1, 0, 0, 1'b0);
    endtask

    task automatic test_same_cycle();
        run_cmd("load_same", 1'b0, 32'h0000_0800, 5'd11, -1, 1, 0, 1'b1);
        run_cmd("store_same_err", 1'b1, 32'h0000_0900, 5'd11, 0, 0, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] old_v;
        int            t0, w0, d0;
        bit            got;
        preload(2, 32'd3, rand_vec());
        old_v = vreg_rd(3);
        ack_delay = 0; resp_delay = 6; same_cycle = 1'b0; err_txn = -1;
        t0 = txn_addr.size(); w0 = wreq_cnt; d0 = done_cnt;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_is_store = 1'b0; cmd_addr = 32'h400; cmd_vreg = 5'd3;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            #1;
            if (txn_addr.size() - t0 >= 2) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL reset_mid lane1: timeout waiting for lane 1 ack");
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || dmem_req !== 1'b0 || seq2mprf_w_req !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid async: ready=%b req=%b wreq=%b done=%b want 1/0/0/0",
                     cmd_ready, dmem_req, seq2mprf_w_req, done);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (done_cnt != d0 || wreq_cnt != w0 || vreg_rd(3) !== old_v) begin
            errors++;
            $display("FAIL reset_mid effects: done=%0d wreq=%0d want 0/0, vreg %h want %h",
                     done_cnt - d0, wreq_cnt - w0, vreg_rd(3), old_v);
        end
        rst_n = 1'b1;
        run_cmd("after_reset", 1'b0, 32'h500, 5'd3, -1, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        bit            st;
        logic [31:0]   addr;
        logic [AW-1:0] vr;
        int            err_at;
        for (int n = 0; n < 20; n++) begin
            st   = 1'($urandom);
            vr   = AW'($urandom);
            addr = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(7, 0) == 0) addr[1:0] = 2'($urandom_range(3, 1));
            err_at = ($urandom_range(4, 0) == 0) ? int'($urandom_range(LANE - 1, 0)) : -1;
            if ($urandom_range(1, 0) == 1) preload(2, 32'(vr), rand_vec());
            run_cmd($sformatf("random%0d", n), st, addr, vr, err_at,
                    int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_store_delayed();
        test_misalign();
        test_resp_error();
        test_store_wrap();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
